// File: rtl/trace_sched.sv
// trace_sched: in-order retire-trace scheduler that holds late-writeback records
// and drains completed ones to a registered valid/ready trace stream.
module trace_sched #(
   parameter int DEPTH = 8,
   parameter int TMO   = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ret_vld,
   output logic        ret_rdy,
   input  logic [31:0] ret_pc,
   input  logic        ret_rd_en,
   input  logic [4:0]  ret_rd_addr,
   input  logic [31:0] ret_rd_data,
   input  logic        ret_rd_pend,
   input  logic [2:0]  ret_mem_wen,
   input  logic [31:0] ret_mem_waddr,
   input  logic [31:0] ret_mem_wdata,
   input  logic        wb1_en,
   input  logic [4:0]  wb1_addr,
   input  logic [31:0] wb1_data,
   input  logic        wb2_en,
   input  logic [4:0]  wb2_addr,
   input  logic [31:0] wb2_data,
   output logic        out_vld,
   input  logic        out_rdy,
   output logic [31:0] out_pc,
   output logic [4:0]  out_rd,
   output logic [31:0] out_rd_data,
   output logic [2:0]  out_mem_wen,
   output logic [31:0] out_mem_waddr,
   output logic [31:0] out_mem_wdata,
   output logic        out_tmo,
   output logic [31:0] rec_cnt,
   output logic        err
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = TMO > 0 ? $clog2(TMO + 1) : 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        pend;
      logic        tmo;
      logic [2:0]  wen;
      logic [31:0] waddr;
      logic [31:0] wdata;
   } rec_t;

   rec_t          mem [DEPTH];
   rec_t          in_rec, hd_rec, nx;
   logic [AW-1:0] head, tail, nh;
   logic [AW:0]   cnt, rem;
   logic [31:0]   pend;
   logic [AW-1:0] ptr [32];
   logic [TW-1:0] tcnt;
   logic          rd_w, rec, full, push, pop, w1, w2, e1, e2, hpend, fire, hit1, hit2, vld_n;

   always_comb begin
      rd_w    = ret_rd_en & (ret_rd_addr != '0);
      rec     = rd_w | (|ret_mem_wen);
      full    = cnt == (AW+1)'(DEPTH);
      ret_rdy = !full & !(rd_w & pend[ret_rd_addr]);
      push    = ret_vld & ret_rdy & rec;
      pop     = out_vld & out_rdy;
      w2      = wb2_en & (wb2_addr != '0) & pend[wb2_addr];
      w1      = wb1_en & (wb1_addr != '0) & pend[wb1_addr] & !(w2 & (wb1_addr == wb2_addr));
      e1      = wb1_en & (wb1_addr != '0) & !pend[wb1_addr];
      e2      = wb2_en & (wb2_addr != '0) & !pend[wb2_addr];
      hd_rec  = mem[head];
      hpend   = (cnt != '0) & hd_rec.pend;
      // a writeback landing in the expiry cycle wins over the timeout
      fire    = (TMO != 0) & hpend & (tcnt == TW'(TMO))
              & !(w1 & (wb1_addr == hd_rec.rd)) & !(w2 & (wb2_addr == hd_rec.rd));
      in_rec.pc    = ret_pc;
      in_rec.rd    = rd_w ? ret_rd_addr : '0;
      in_rec.pend  = rd_w & ret_rd_pend;
      in_rec.data  = (rd_w & !ret_rd_pend) ? ret_rd_data : '0;
      in_rec.tmo   = 1'b0;
      in_rec.wen   = ret_mem_wen;
      in_rec.waddr = |ret_mem_wen ? ret_mem_waddr : '0;
      in_rec.wdata = ret_mem_wen[0] ? {24'd0, ret_mem_wdata[7:0]} :
                     ret_mem_wen[1] ? {16'd0, ret_mem_wdata[15:0]} :
                     ret_mem_wen[2] ? ret_mem_wdata : '0;
      nh      = head + AW'(pop);
      rem     = cnt - (AW+1)'(pop);
      // next head contents, with this cycle's push/writeback/timeout merged in
      nx      = (rem == '0) ? in_rec : mem[nh];
      hit1    = w1 & (ptr[wb1_addr] == nh) & (rem != '0);
      hit2    = w2 & (ptr[wb2_addr] == nh) & (rem != '0);
      nx.data = fire ? '0 : hit2 ? wb2_data : hit1 ? wb1_data : nx.data;
      nx.pend = nx.pend & !hit1 & !hit2 & !fire;
      nx.tmo  = nx.tmo | fire;
      vld_n   = (rem == '0) ? (push & !in_rec.pend) : !nx.pend;
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[tail] <= in_rec;
      if (w1) begin
         mem[ptr[wb1_addr]].data <= wb1_data;
         mem[ptr[wb1_addr]].pend <= 1'b0;
      end
      if (w2) begin
         mem[ptr[wb2_addr]].data <= wb2_data;
         mem[ptr[wb2_addr]].pend <= 1'b0;
      end
      if (fire) begin
         mem[head].data <= '0;
         mem[head].pend <= 1'b0;
         mem[head].tmo  <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head          <= '0;
         tail          <= '0;
         cnt           <= '0;
         pend          <= '0;
         tcnt          <= '0;
         rec_cnt       <= '0;
         err           <= 1'b0;
         out_vld       <= 1'b0;
         out_pc        <= '0;
         out_rd        <= '0;
         out_rd_data   <= '0;
         out_mem_wen   <= '0;
         out_mem_waddr <= '0;
         out_mem_wdata <= '0;
         out_tmo       <= 1'b0;
      end else begin
         head    <= nh;
         tail    <= tail + AW'(push);
         cnt     <= rem + (AW+1)'(push);
         if (w1) pend[wb1_addr] <= 1'b0;
         if (w2) pend[wb2_addr] <= 1'b0;
         if (fire) pend[hd_rec.rd] <= 1'b0;
         if (push & in_rec.pend) begin
            pend[ret_rd_addr] <= 1'b1;
            ptr[ret_rd_addr]  <= tail;
         end
         tcnt          <= (pop | !hpend | fire) ? '0 : tcnt + TW'(1);
         rec_cnt       <= rec_cnt + 32'(pop);
         err           <= err | e1 | e2;
         out_vld       <= vld_n;
         out_pc        <= nx.pc;
         out_rd        <= nx.rd;
         out_rd_data   <= nx.data;
         out_mem_wen   <= nx.wen;
         out_mem_waddr <= nx.waddr;
         out_mem_wdata <= nx.wdata;
         out_tmo       <= nx.tmo;
      end
   end
endmodule

// File: tb/tb_trace_sched.sv
// tb_trace_sched: table-driven vectors plus directed multi-cycle sequences for trace_sched.
module tb_trace_sched;
   logic        clk_i = 1'b0, rst_i;
   logic        ret_vld, ret_rdy, ret_rd_en, ret_rd_pend;
   logic [31:0] ret_pc, ret_rd_data, ret_mem_waddr, ret_mem_wdata;
   logic [4:0]  ret_rd_addr;
   logic [2:0]  ret_mem_wen;
   logic        wb1_en, wb2_en;
   logic [4:0]  wb1_addr, wb2_addr;
   logic [31:0] wb1_data, wb2_data;
   logic        out_vld, out_rdy, out_tmo, err;
   logic [31:0] out_pc, out_rd_data, out_mem_waddr, out_mem_wdata, rec_cnt;
   logic [4:0]  out_rd;
   logic [2:0]  out_mem_wen;

   always #5 clk_i = ~clk_i;

   trace_sched #(.DEPTH(8), .TMO(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ret_vld(ret_vld), .ret_rdy(ret_rdy), .ret_pc(ret_pc),
      .ret_rd_en(ret_rd_en), .ret_rd_addr(ret_rd_addr), .ret_rd_data(ret_rd_data),
      .ret_rd_pend(ret_rd_pend), .ret_mem_wen(ret_mem_wen), .ret_mem_waddr(ret_mem_waddr),
      .ret_mem_wdata(ret_mem_wdata), .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
      .wb2_en(wb2_en), .wb2_addr(wb2_addr), .wb2_data(wb2_data), .out_vld(out_vld),
      .out_rdy(out_rdy), .out_pc(out_pc), .out_rd(out_rd), .out_rd_data(out_rd_data),
      .out_mem_wen(out_mem_wen), .out_mem_waddr(out_mem_waddr), .out_mem_wdata(out_mem_wdata),
      .out_tmo(out_tmo), .rec_cnt(rec_cnt), .err(err)
   );

   typedef struct {
      logic [31:0] pc;
      logic        en;
      logic [4:0]  rd;
      logic [31:0] d;
      logic [2:0]  wen;
      logic [31:0] wa, wd;
      logic        xv;
      logic [4:0]  xrd;
      logic [31:0] xd;
      logic [2:0]  xwen;
      logic [31:0] xwa, xwd;
   } vec_t;

   vec_t tv[9];
   int   nvec = 0, nerr = 0;
   int   exp_rc = 0;
   int   k;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic en, input logic [4:0] rd,
                         input logic [31:0] d, input logic p, input logic [2:0] wen,
                         input logic [31:0] wa, input logic [31:0] wd);
      ret_vld = 1'b1; ret_pc = pc; ret_rd_en = en; ret_rd_addr = rd; ret_rd_data = d;
      ret_rd_pend = p; ret_mem_wen = wen; ret_mem_waddr = wa; ret_mem_wdata = wd;
   endtask

   task automatic chk_out(input string nm, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] d);
      chk({nm, "_vld"}, {31'd0, out_vld}, 32'd1);
      chk({nm, "_pc"}, out_pc, pc);
      chk({nm, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
      chk({nm, "_data"}, out_rd_data, d);
   endtask

   initial begin
      tv[0] = '{32'h100, 1, 10, 32'h5,        3'b000, 32'h0,    32'h0,        1, 10, 32'h5,        3'b000, 32'h0,    32'h0};
      tv[1] = '{32'h104, 0, 0,  32'h0,        3'b001, 32'h2000, 32'hDEADBEEF, 1, 0,  32'h0,        3'b001, 32'h2000, 32'hEF};
      tv[2] = '{32'h108, 0, 0,  32'h0,        3'b010, 32'h2000, 32'hDEADBEEF, 1, 0,  32'h0,        3'b010, 32'h2000, 32'hBEEF};
      tv[3] = '{32'h10C, 0, 0,  32'h0,        3'b100, 32'h2004, 32'hDEADBEEF, 1, 0,  32'h0,        3'b100, 32'h2004, 32'hDEADBEEF};
      tv[4] = '{32'h110, 1, 0,  32'h44,       3'b000, 32'h0,    32'h0,        0, 0,  32'h0,        3'b000, 32'h0,    32'h0};
      tv[5] = '{32'h114, 0, 7,  32'h123,      3'b000, 32'h0,    32'h0,        0, 0,  32'h0,        3'b000, 32'h0,    32'h0};
      tv[6] = '{32'h118, 0, 9,  32'h123,      3'b100, 32'h3000, 32'hCAFEF00D, 1, 0,  32'h0,        3'b100, 32'h3000, 32'hCAFEF00D};
      tv[7] = '{32'h11C, 1, 31, 32'hFFFFFFFF, 3'b001, 32'h10,   32'h1234,     1, 31, 32'hFFFFFFFF, 3'b001, 32'h10,   32'h34};
      tv[8] = '{32'h120, 1, 1,  32'hA5A5,     3'b000, 32'h999,  32'h777,      1, 1,  32'hA5A5,     3'b000, 32'h0,    32'h0};

      rst_i = 1'b1; out_rdy = 1'b1;
      retire(0, 0, 0, 0, 0, 0, 0, 0); ret_vld = 1'b0;
      wb1_en = 0; wb1_addr = 0; wb1_data = 0; wb2_en = 0; wb2_addr = 0; wb2_data = 0;
      tick; tick;
      rst_i = 1'b0;
      chk("rst_out_vld", {31'd0, out_vld}, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_wdata", out_mem_wdata, 0);
      chk("rst_rec_cnt", rec_cnt, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_ret_rdy", {31'd0, ret_rdy}, 1);

      // back-to-back retires, one per cycle
      for (int i = 0; i < 9; i++) begin
         retire(tv[i].pc, tv[i].en, tv[i].rd, tv[i].d, 1'b0, tv[i].wen, tv[i].wa, tv[i].wd);
         #1 chk($sformatf("v%0d_ret_rdy", i), {31'd0, ret_rdy}, 1);
         tick;
         chk($sformatf("v%0d_vld", i), {31'd0, out_vld}, {31'd0, tv[i].xv});
         chk($sformatf("v%0d_rec_cnt", i), rec_cnt, exp_rc);
         if (tv[i].xv) begin
            chk_out($sformatf("v%0d", i), tv[i].pc, tv[i].xrd, tv[i].xd);
            chk($sformatf("v%0d_wen", i), {29'd0, out_mem_wen}, {29'd0, tv[i].xwen});
            chk($sformatf("v%0d_waddr", i), out_mem_waddr, tv[i].xwa);
            chk($sformatf("v%0d_wdata", i), out_mem_wdata, tv[i].xwd);
            chk($sformatf("v%0d_tmo", i), {31'd0, out_tmo}, 0);
         end
         exp_rc += int'(tv[i].xv);
      end
      ret_vld = 1'b0;
      tick;
      chk("tbl_end_vld", {31'd0, out_vld}, 0);
      chk("tbl_end_rec_cnt", rec_cnt, 7);
      exp_rc = 7;

      // pending load blocks a younger completed record until wb1
      retire(32'h200, 1, 5, 0, 1, 0, 0, 0); tick;
      retire(32'h204, 1, 6, 32'h66, 0, 0, 0, 0); tick;
      ret_vld = 1'b0;
      chk("ld_wait0", {31'd0, out_vld}, 0); tick;
      chk("ld_wait1", {31'd0, out_vld}, 0);
      wb1_en = 1; wb1_addr = 5; wb1_data = 32'h77;
      tick; wb1_en = 0;
      chk_out("ld_rd5", 32'h200, 5, 32'h77); tick;
      chk_out("ld_rd6", 32'h204, 6, 32'h66); tick;
      chk("ld_done", {31'd0, out_vld}, 0);
      exp_rc += 2;
      chk("ld_rec_cnt", rec_cnt, exp_rc);

      // WAW stall, then both ports hit the same register
      retire(32'h300, 1, 5, 0, 1, 0, 0, 0); tick;
      retire(32'h304, 1, 5, 32'h55, 0, 0, 0, 0);
      #1 chk("waw_stall0", {31'd0, ret_rdy}, 0); tick;
      chk("waw_stall1", {31'd0, ret_rdy}, 0);
      wb1_en = 1; wb1_addr = 5; wb1_data = 32'h11;
      wb2_en = 1; wb2_addr = 5; wb2_data = 32'h22;
      #1 chk("waw_no_bypass", {31'd0, ret_rdy}, 0);
      tick; wb1_en = 0; wb2_en = 0;
      chk_out("waw_first", 32'h300, 5, 32'h22);
      chk("waw_release", {31'd0, ret_rdy}, 1);
      tick; ret_vld = 1'b0;
      chk_out("waw_second", 32'h304, 5, 32'h55); tick;
      chk("waw_done", {31'd0, out_vld}, 0);
      chk("waw_err", {31'd0, err}, 0);
      exp_rc += 2;

      // two distinct pending registers resolved in one cycle
      retire(32'h700, 1, 8, 0, 1, 0, 0, 0); tick;
      retire(32'h704, 1, 9, 0, 1, 0, 0, 0); tick;
      ret_vld = 1'b0;
      wb1_en = 1; wb1_addr = 9; wb1_data = 32'h99;
      wb2_en = 1; wb2_addr = 8; wb2_data = 32'h88;
      tick; wb1_en = 0; wb2_en = 0;
      chk_out("dual_rd8", 32'h700, 8, 32'h88); tick;
      chk_out("dual_rd9", 32'h704, 9, 32'h99); tick;
      chk("dual_done", {31'd0, out_vld}, 0);
      chk("dual_err", {31'd0, err}, 0);
      exp_rc += 2;

      // fill to DEPTH with a stalled consumer, then drain across the wrap
      out_rdy = 1'b0;
      for (int i = 0; i < 9; i++) begin
         retire(32'h400 + 4 * i, 1, 5'(11 + i), 32'h1000 + i, 0, 0, 0, 0);
         #1 chk($sformatf("fill%0d_ret_rdy", i), {31'd0, ret_rdy}, (i < 8) ? 32'd1 : 32'd0);
         tick;
         chk_out($sformatf("fill%0d_hold", i), 32'h400, 11, 32'h1000);
      end
      ret_vld = 1'b0; out_rdy = 1'b1;
      for (int j = 0; j < 8; j++) begin
         chk_out($sformatf("drain%0d", j), 32'h400 + 4 * j, 5'(11 + j), 32'h1000 + j);
         tick;
      end
      chk("drain_done", {31'd0, out_vld}, 0);
      exp_rc += 8;
      chk("drain_rec_cnt", rec_cnt, exp_rc);

      // orphan writeback raises a sticky error
      wb1_en = 1; wb1_addr = 3; wb1_data = 32'h1;
      #1 chk("orphan_pre", {31'd0, err}, 0);
      tick; wb1_en = 0;
      chk("orphan_err", {31'd0, err}, 1); tick;
      chk("orphan_sticky", {31'd0, err}, 1);

      // reset mid-operation discards buffered and pending state
      out_rdy = 1'b0;
      retire(32'h600, 1, 12, 0, 1, 0, 0, 0); tick;
      retire(32'h604, 1, 13, 32'h13, 0, 0, 0, 0); tick;
      ret_vld = 1'b0; rst_i = 1'b1; tick; rst_i = 1'b0;
      chk("mrst_vld", {31'd0, out_vld}, 0);
      chk("mrst_rec_cnt", rec_cnt, 0);
      chk("mrst_err", {31'd0, err}, 0);
      tick;
      chk("mrst_quiet", {31'd0, out_vld}, 0);
      retire(32'h608, 1, 12, 32'hC, 0, 0, 0, 0);
      #1 chk("mrst_pend_clear", {31'd0, ret_rdy}, 1);
      tick; ret_vld = 1'b0; out_rdy = 1'b1;
      chk_out("mrst_new", 32'h608, 12, 32'hC); tick;
      chk("mrst_rec_cnt1", rec_cnt, 1);

      // timeout on a pending head, then the late wb is an orphan
      retire(32'h800, 1, 7, 0, 1, 0, 0, 0); tick;
      ret_vld = 1'b0;
      for (k = 1; k <= 12; k++) begin
         if (out_vld) break;
         tick;
      end
      chk("tmo_not_early", {31'd0, k >= 4}, 1);
      chk("tmo_in_time", {31'd0, k <= 7}, 1);
      chk_out("tmo_rec", 32'h800, 7, 32'h0);
      chk("tmo_flag", {31'd0, out_tmo}, 1);
      tick;
      chk("tmo_popped", {31'd0, out_vld}, 0);
      wb1_en = 1; wb1_addr = 7; wb1_data = 32'h7;
      #1 chk("tmo_err_pre", {31'd0, err}, 0);
      tick; wb1_en = 0;
      chk("tmo_late_wb_err", {31'd0, err}, 1);
      chk("tmo_rec_cnt", rec_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
